// File: rtl/fetch_bp_unit.sv
// -----------------------------------------------------------------------------
// fetch_bp_unit
//
// Fetch stage for the 5-stage RV32 pipeline. Owns PC_fe and drives the
// instruction-memory address. A direct-mapped BTB with 2-bit saturating
// counters predicts taken branches/jumps at fetch time. EX-stage resolution
// trains the BTB, and any disagreement with the fetch-time prediction raises
// a combinational redirect that also flushes the DE/EX pipeline registers.
//
// Optional feature macro: FETCH_BP_PERF_CNT_EN
//   When defined, adds saturating performance counters for resolved
//   branches and mispredicts (perf_branches_o / perf_mispred_o).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_i             hazard-unit stall, holds PC (a redirect overrides it)
//   pc_o                fetch address
//   pred_taken_o        BTB prediction for pc_o
//   pred_target_o       predicted target for pc_o (0 on BTB miss)
//   upd_valid_i         EX holds a resolved branch/jump this cycle
//   upd_pc_i            PC of the resolved instruction
//   upd_taken_i         actual outcome
//   upd_target_i        actual target
//   upd_pred_taken_i    prediction that was made for it in fetch
//   upd_pred_target_i   target that was predicted for it in fetch
//   mispredict_o        redirect request (combinational)
//   flush_o             DE/EX flush, identical to mispredict_o
//   perf_branches_o     resolved-update count      (FETCH_BP_PERF_CNT_EN)
//   perf_mispred_o      mispredict count           (FETCH_BP_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module fetch_bp_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
`ifdef FETCH_BP_PERF_CNT_EN
  ,
  parameter int unsigned     PERF_W      = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            mispredict_o,
`ifdef FETCH_BP_PERF_CNT_EN
  output logic            flush_o,
  output logic [PERF_W-1:0] perf_branches_o,
  output logic [PERF_W-1:0] perf_mispred_o
`else
  output logic            flush_o
`endif
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  // 2-bit saturating counter steps
  function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [XLEN-1:0]        pc_q, pc_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_d [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];
  logic [1:0]             ctr_d [BTB_ENTRIES];

  logic [IDX-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic             mispredict;

  // Lookup: fully combinational on the current PC; bits [1:0] are ignored.
  always_comb begin
    lk_idx        = pc_q[IDX+1:2];
    lk_tag        = pc_q[XLEN-1:IDX+2];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
    pred_target_o = lk_hit ? tgt_q[lk_idx] : '0;
  end

  // Mispredict covers both a wrong direction and a taken branch whose
  // predicted target was wrong.
  always_comb begin
    mispredict = upd_valid_i &&
                 ((upd_taken_i != upd_pred_taken_i) ||
                  (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  end

  assign mispredict_o = mispredict;
  assign flush_o      = mispredict;
  assign pc_o         = pc_q;

  // Next PC: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (mispredict) begin
      pc_d = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (pred_taken_o) begin
      pc_d = pred_target_o;
    end
  end

  // BTB training. Computed from current contents, so a same-cycle lookup of
  // the entry being written still sees the old value.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    upd_idx = upd_pc_i[IDX+1:2];
    upd_tag = upd_pc_i[XLEN-1:IDX+2];
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = upd_taken_i ? ctr_sat_inc(ctr_q[upd_idx])
                                     : ctr_sat_dec(ctr_q[upd_idx]);
        if (upd_taken_i) begin
          tgt_d[upd_idx] = upd_target_i;
        end
      end else if (upd_taken_i) begin
        // Allocate (evicting any alias) as weakly taken.
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        tgt_d[upd_idx]   = upd_target_i;
        ctr_d[upd_idx]   = 2'b10;
      end
    end
  end

  // Control state: PC and valid bits are cleared by reset, which also
  // discards any update presented while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // BTB payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    ctr_q <= ctr_d;
  end

`ifdef FETCH_BP_PERF_CNT_EN
  logic [PERF_W-1:0] br_cnt_q, br_cnt_d;
  logic [PERF_W-1:0] mp_cnt_q, mp_cnt_d;

  // Saturating event counters
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (upd_valid_i && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + PERF_W'(1);
    end
    if (mispredict && (mp_cnt_q != '1)) begin
      mp_cnt_d = mp_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign perf_branches_o = br_cnt_q;
  assign perf_mispred_o  = mp_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_bp_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_bp_unit
//
// Scoreboard bench for fetch_bp_unit (default parameters). The driver issues
// one cycle of stimulus per negedge, predicts that cycle's outputs from a
// behavioural BTB model and queues them; an independent monitor pops each
// expectation shortly after and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fetch_bp_unit;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_pred_taken_i = 1'b0;
  logic [31:0] upd_pred_target_i = '0;
  logic        mispredict_o;
  logic        flush_o;
`ifdef FETCH_BP_PERF_CNT_EN
  logic [31:0] perf_branches_o;
  logic [31:0] perf_mispred_o;
`endif

  always #5 clk = ~clk;

  fetch_bp_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .pc_o              (pc_o),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .mispredict_o      (mispredict_o),
`ifdef FETCH_BP_PERF_CNT_EN
    .flush_o           (flush_o),
    .perf_branches_o   (perf_branches_o),
    .perf_mispred_o    (perf_mispred_o)
`else
    .flush_o           (flush_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] nbr;
    logic [31:0] nmp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: a table of entries keyed by word address modulo N,
  // each remembering which block (pc / 4N) owns it.
  logic [31:0] m_pc;
  bit          m_v   [N];
  logic [31:0] m_blk [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];
  logic [31:0] m_br, m_mp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_br = 0;
    m_mp = 0;
  endfunction

  task automatic step(input bit rst, input bit st, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit upt,
                      input logic [31:0] uptgt);
    exp_t        e;
    int          li, ui;
    bit          hit, mp;
    logic [31:0] npc;
    @(negedge clk);
    rst_n = rst; stall_i = st; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    upd_target_i = utgt; upd_pred_taken_i = upt; upd_pred_target_i = uptgt;
    if (!rst) model_reset();
    li    = int'((m_pc / 4) % N);
    hit   = m_v[li] && (m_blk[li] == m_pc / (4 * N));
    e.pc  = m_pc;
    e.pt  = hit && (m_ctr[li] >= 2);
    e.ptg = hit ? m_tgt[li] : 32'h0;
    mp    = uv && ((ut != upt) || (ut && (utgt != uptgt)));
    e.mp  = mp;
    e.nbr = m_br;
    e.nmp = m_mp;
    #1;
    exp_q.push_back(e);
    if (rst) begin
      if (mp)        npc = ut ? utgt : upc + 32'd4;
      else if (st)   npc = m_pc;
      else if (e.pt) npc = e.ptg;
      else           npc = m_pc + 32'd4;
      if (uv) begin
        ui = int'((upc / 4) % N);
        if (m_v[ui] && (m_blk[ui] == upc / (4 * N))) begin
          if (ut) begin
            m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            m_tgt[ui] = utgt;
          end else begin
            m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
          end
        end else if (ut) begin
          m_v[ui]   = 1'b1;
          m_blk[ui] = upc / (4 * N);
          m_tgt[ui] = utgt;
          m_ctr[ui] = 2;
        end
      end
      if (uv && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (mp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      m_pc = npc;
    end
  endtask

  task automatic idle(input bit st);
    step(1'b1, st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                     input bit upt, input logic [31:0] uptgt);
    step(1'b1, 1'b0, 1'b1, upc, ut, utgt, upt, uptgt);
  endtask

  // Redirect fetch to 0x10 via a not-taken resolution of 0xC that was
  // predicted taken (0xC is never allocated).
  task automatic go10();
    upd(32'h0C, 1'b0, 32'h0, 1'b1, 32'h0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("pred_taken_o", {31'b0, pred_taken_o}, {31'b0, e.pt});
        chk("pred_target_o", pred_target_o, e.ptg);
        chk("mispredict_o", {31'b0, mispredict_o}, {31'b0, e.mp});
        chk("flush_o", {31'b0, flush_o}, {31'b0, e.mp});
`ifdef FETCH_BP_PERF_CNT_EN
        chk("perf_branches_o", perf_branches_o, e.nbr);
        chk("perf_mispred_o", perf_mispred_o, e.nmp);
`endif
      end
    end
  end

  // Driver
  initial begin
    model_reset();
    // Reset, then free run with a two-cycle stall at 0x8
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    idle(0); idle(0); idle(1); idle(1); idle(0); idle(0); idle(0);
    // Mid-run reset with an update in flight that must be discarded
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h60, 1'b0, 32'h0);
    idle(0); idle(0);
    // First taken resolution allocates and redirects
    upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    idle(0);
    go10(); idle(0); idle(0);
    // Hysteresis on 0x10: NT -> 01, T -> 10, T -> 11, NT -> 10
    upd(32'h10, 1'b0, 32'h0, 1'b1, 32'h40); go10(); idle(0);
    upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h0); go10(); idle(0);
    upd(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
    upd(32'h10, 1'b0, 32'h0, 1'b1, 32'h40); go10(); idle(0);
    // Alias 0x50 on the entry owned by 0x10, then evict it
    upd(32'h4C, 1'b0, 32'h0, 1'b1, 32'h0); idle(0);
    upd(32'h50, 1'b1, 32'h80, 1'b0, 32'h0); idle(0);
    go10(); idle(0);
    upd(32'h4C, 1'b0, 32'h0, 1'b1, 32'h0); idle(0);
    // Redirect wins over a simultaneous stall
    step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    idle(0);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [31:0] upc, utgt, uptgt;
      bit          rr, st, uv, ut, upt;
      rr    = ($urandom_range(0, 79) != 0);
      st    = ($urandom_range(0, 3) == 0);
      uv    = ($urandom_range(0, 2) != 0);
      upc   = $urandom_range(0, 31) * 4;
      ut    = $urandom_range(0, 1);
      utgt  = $urandom_range(0, 63) * 4;
      upt   = $urandom_range(0, 1);
      uptgt = ($urandom_range(0, 1) != 0) ? utgt : $urandom_range(0, 63) * 4;
      step(rr, st, uv, upc, ut, utgt, upt, uptgt);
    end
    @(negedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
